input_conditioner: RTL and testbench



---
 rtl/input_cond_pkg.sv | 13 +
 rtl/debounce_channel.sv | 119 +++++++++++
 rtl/input_conditioner.sv | 41 ++++
 tb/tb_input_conditioner.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/input_cond_pkg.sv
// rtl/input_cond_pkg.sv - shared types and constants for the input conditioner
package input_cond_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } deb_state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - synchronizer plus counter debounce for one input; strobes built only with INPUT_COND_EDGE_EN
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    deb_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], raw};
    assign s      = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            STABLE_LO: begin
                if (s) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    // Output registered from next state so it changes on the same edge as the state
    assign level_d = (state_d == STABLE_HI) || (state_d == WAIT_LO);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

`ifdef INPUT_COND_EDGE_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    assign rise_d = level_d & ~level_q;
    assign fall_d = ~level_d & level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - two independent debounced channels A and B; strobes enabled by INPUT_COND_EDGE_EN
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic a_raw,
    input  logic b_raw,
    output logic A,
    output logic B,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_a (
        .clk  (clk),
        .reset(reset),
        .raw  (a_raw),
        .level(A),
        .rise (a_rise),
        .fall (a_fall)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_b (
        .clk  (clk),
        .reset(reset),
        .raw  (b_raw),
        .level(B),
        .rise (b_rise),
        .fall (b_fall)
    );

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - self-checking bench for input_conditioner, both INPUT_COND_EDGE_EN builds
module tb_input_conditioner;
    import input_cond_pkg::*;

    localparam int DEB = 4;
`ifdef INPUT_COND_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic a_raw = 1'b1;
    logic b_raw = 1'b1;
    logic A, B, a_rise, a_fall, b_rise, b_fall;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    input_conditioner #(.DEBOUNCE_CYCLES(DEB)) u_dut (
        .clk   (clk),
        .reset (reset),
        .a_raw (a_raw),
        .b_raw (b_raw),
        .A     (A),
        .B     (B),
        .a_rise(a_rise),
        .a_fall(a_fall),
        .b_rise(b_rise),
        .b_fall(b_fall)
    );

    task automatic check(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: two-sample delay line, then an output that flips once the delayed
    // input has disagreed with it on DEB consecutive samples.
    logic m_s1[2], m_s2[2], m_out[2], m_rise[2], m_fall[2];
    int   m_run[2];

    initial begin
        for (int ch = 0; ch < 2; ch++) begin
            m_s1[ch] = 0; m_s2[ch] = 0; m_out[ch] = 0;
            m_rise[ch] = 0; m_fall[ch] = 0; m_run[ch] = 0;
        end
    end

    always @(posedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (reset) begin
                m_s1[ch] <= 0; m_s2[ch] <= 0; m_out[ch] <= 0;
                m_rise[ch] <= 0; m_fall[ch] <= 0; m_run[ch] <= 0;
            end else begin
                m_s1[ch] <= (ch == 0) ? a_raw : b_raw;
                m_s2[ch] <= m_s1[ch];
                m_rise[ch] <= 0;
                m_fall[ch] <= 0;
                if (m_s2[ch] != m_out[ch]) begin
                    if (m_run[ch] + 1 >= DEB) begin
                        m_out[ch]  <= ~m_out[ch];
                        m_run[ch]  <= 0;
                        m_rise[ch] <= ~m_out[ch];
                        m_fall[ch] <= m_out[ch];
                    end else begin
                        m_run[ch] <= m_run[ch] + 1;
                    end
                end else begin
                    m_run[ch] <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_A", A, m_out[0]);
            check("cmp_B", B, m_out[1]);
            check("cmp_a_rise", a_rise, EDGE_EN ? m_rise[0] : 1'b0);
            check("cmp_a_fall", a_fall, EDGE_EN ? m_fall[0] : 1'b0);
            check("cmp_b_rise", b_rise, EDGE_EN ? m_rise[1] : 1'b0);
            check("cmp_b_fall", b_fall, EDGE_EN ? m_fall[1] : 1'b0);
        end
    end

    task automatic step(logic a, logic b);
        a_raw = a;
        b_raw = b;
        @(posedge clk);
        #2;
    endtask

    task automatic hold(logic a, logic b, int n);
        for (int i = 0; i < n; i++) step(a, b);
    endtask

    initial begin
        int highs;
        int strobes;
        logic bounce[9];

        @(posedge clk);
        #2;
        chk_en = 1'b1;

        // Reset held with both raw inputs high
        for (int i = 0; i < 3; i++) begin
            step(1, 1);
            check("rst_A", A, 1'b0);
            check("rst_B", B, 1'b0);
            check("rst_strobes", a_rise | a_fall | b_rise | b_fall, 1'b0);
        end
        reset = 1'b0;
        hold(1, 1, 5);
        check("post_rst_A_e5", A, 1'b0);
        check("post_rst_B_e5", B, 1'b0);
        step(1, 1);
        check("post_rst_A_e6", A, 1'b1);
        check("post_rst_B_e6", B, 1'b1);
        check("post_rst_a_rise", a_rise, EDGE_EN);
        check("post_rst_b_rise", b_rise, EDGE_EN);
        step(1, 1);
        check("a_rise_one_cycle", a_rise, 1'b0);

        // Clean falling step
        hold(0, 1, 5);
        check("fall_A_e5", A, 1'b1);
        step(0, 1);
        check("fall_A_e6", A, 1'b0);
        check("fall_a_fall", a_fall, EDGE_EN);
        step(0, 1);
        check("a_fall_one_cycle", a_fall, 1'b0);
        hold(0, 1, 4);

        // 3-edge glitch is rejected
        highs = 0;
        strobes = 0;
        for (int i = 0; i < 12; i++) begin
            step(i < 3, 1);
            highs += int'(A);
            strobes += int'(a_rise | a_fall);
        end
        check("glitch3_no_A", highs != 0, 1'b0);
        check("glitch3_no_strobe", strobes != 0, 1'b0);

        // 4-edge pulse passes and yields a 4-cycle output pulse
        highs = 0;
        for (int i = 0; i < 14; i++) begin
            step(i < 4, 1);
            if (i == 4) check("pulse4_A_e5", A, 1'b0);
            if (i == 5) check("pulse4_A_e6", A, 1'b1);
            if (i == 9) check("pulse4_A_e10", A, 1'b0);
            highs += int'(A);
        end
        check("pulse4_width_is_4", highs == 4, 1'b1);

        // Bounce: final stable run starts at index 5, so A rises at index 10
        bounce = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
        for (int i = 0; i < 12; i++) begin
            step((i < 9) ? bounce[i] : 1'b1, 1);
            if (i == 9)  check("bounce_A_i9", A, 1'b0);
            if (i == 10) check("bounce_A_i10", A, 1'b1);
        end
        hold(0, 1, 12);

        // Mid-operation reset while A is in WAIT_HI with cnt=2
        hold(1, 1, 4);
        check("mid_state_wait_hi", u_dut.u_a.state_q == WAIT_HI, 1'b1);
        check("mid_cnt_2", u_dut.u_a.cnt_q == 2, 1'b1);
        reset = 1'b1;
        step(1, 1);
        check("mid_rst_A", A, 1'b0);
        check("mid_rst_state", u_dut.u_a.state_q == STABLE_LO, 1'b1);
        reset = 1'b0;
        hold(1, 1, 5);
        check("mid_rel_A_e5", A, 1'b0);
        step(1, 1);
        check("mid_rel_A_e6", A, 1'b1);

        // Both channels step together
        hold(0, 0, 10);
        hold(1, 1, 5);
        check("indep_A_e5", A, 1'b0);
        check("indep_B_e5", B, 1'b0);
        step(1, 1);
        check("indep_A_e6", A, 1'b1);
        check("indep_B_e6", B, 1'b1);
        hold(1, 1, 3);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
